// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core priority with a
// debug starvation guard, read-merge-write for sub-word stores, registered responses.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic        c_err,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  sc_r;
  logic        d_pri_s;
  logic        sel_we_s;
  logic        sel_err_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [31:0] load_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] a);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00:   m[{a, 3'b000} +: 8]     = wd[7:0];
      2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   m = wd;
      default: m = old;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] size,
                                          input logic [1:0] a);
    logic [31:0] r;
    case (size)
      2'b00:   r = {24'h000000, rd[{a, 3'b000} +: 8]};
      2'b01:   r = {16'h0000, rd[{a[1], 4'b0000} +: 16]};
      2'b10:   r = rd;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Grant decision; D wins only when C has starved it for STARVE_LIMIT grants
  always_comb begin
    d_pri_s = d_req && (sc_r == LIMIT);
    c_gnt   = !rst && c_req && !d_pri_s;
    d_gnt   = !rst && d_req && (!c_req || d_pri_s);
  end

  // Steer the granted (or idle-default C) request onto the memory port
  always_comb begin
    if (d_gnt) begin
      sel_we_s    = d_we;
      sel_size_s  = d_size;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
    end else begin
      sel_we_s    = c_we;
      sel_size_s  = c_size;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
    end
    sel_err_s = misaligned(sel_size_s, sel_addr_s[1:0]);
    mem_addr  = {sel_addr_s[31:2], 2'b00};
    mem_we    = (c_gnt || d_gnt) && sel_we_s && !sel_err_s;
    mem_wd    = merge(mem_rd, sel_wdata_s, sel_size_s, sel_addr_s[1:0]);
    if (sel_we_s || sel_err_s) begin
      load_s = 32'h00000000;
    end else begin
      load_s = extract(mem_rd, sel_size_s, sel_addr_s[1:0]);
    end
  end

  // Starvation counter: counts C grants while D waits, saturating at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_r <= 4'h0;
    end else if (!d_req || d_gnt) begin
      sc_r <= 4'h0;
    end else if (c_gnt && (sc_r != LIMIT)) begin
      sc_r <= sc_r + 4'h1;
    end
  end

  // Response registers; rdata/err hold until the next response on the same port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      c_err    <= 1'b0;
      c_rdata  <= 32'h00000000;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= 32'h00000000;
    end else begin
      c_rvalid <= c_gnt;
      d_rvalid <= d_gnt;
      if (c_gnt) begin
        c_err   <= sel_err_s;
        c_rdata <= load_s;
      end
      if (d_gnt) begin
        d_err   <= sel_err_s;
        d_rdata <= load_s;
      end
    end
  end

endmodule
